uart_host_bridge: RTL and testbench

Host-side end of the SoC UART link: a synthesizable UART transmitter/receiver pair that connects to the SoC's `uart_rx`/`uart_tx` pins in simulation and FPGA test harnesses. It lets a bench or host-side logic send bytes into the SoC and collect bytes the SoC prints. The link is 8N1, LSB first. Byte-level valid/ready handshakes face the host side, and received bytes are buffered in a FIFO.

---
 rtl/uart_host_pkg.sv | 29 ++
 rtl/uart_host_fifo.sv | 52 +++++
 rtl/uart_host_bridge.sv | 223 ++++++++++++++++++++++
 tb/tb_uart_host_bridge.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_host_pkg.sv
// uart_host_pkg: shared types and helpers for the host-side UART bridge.
//   tx_state_t / rx_state_t : transmit and receive FSM encodings
//   UART_DATA_BITS          : data bits per 8N1 frame
//   calc_cpb()              : clocks per bit (truncating division)
package uart_host_pkg;

  localparam int unsigned UART_DATA_BITS = 8;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_BREAK
  } rx_state_t;

  function automatic int unsigned calc_cpb(input int unsigned clk_hz,
                                           input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_host_fifo.sv
// uart_host_fifo: synchronous FIFO for received bytes.
//   clk, rst_n        : clock, asynchronous active-low reset
//   push, push_data   : write request / data (dropped when full unless popping)
//   pop, pop_data     : read request / head entry (pop ignored when empty)
//   full, empty       : occupancy flags
// DEPTH must be a power of two >= 2; pointers carry one extra wrap bit.
module uart_host_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A simultaneous pop frees the slot, so a push while full still lands.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/uart_host_bridge.sv
// uart_host_bridge: host-side 8N1 UART transmitter/receiver, LSB first.
//   clock, reset        : single clock, asynchronous active-low reset
//   serial_rx/serial_tx : line from SoC uart_tx / line to SoC uart_rx
//   tx_data/valid/ready : byte transmit handshake (accept on valid && ready)
//   rx_data/valid/ready : receive buffer head and pop handshake
//   rx_overflow         : pulse when a received byte is dropped (buffer full)
//   rx_frame_error      : pulse when a stop bit samples low
// Build option UART_HOST_RX_FIFO_EN: defined -> RX_FIFO_DEPTH-entry FIFO;
// undefined -> single-byte holding register.
module uart_host_bridge
  import uart_host_pkg::*;
#(
  parameter int unsigned CLOCK_FREQUENCY = 50000000,
  parameter int unsigned UART_BAUD_RATE  = 9600,
  parameter int unsigned RX_FIFO_DEPTH   = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      serial_rx,
  output logic                      serial_tx,
  input  logic [UART_DATA_BITS-1:0] tx_data,
  input  logic                      tx_valid,
  output logic                      tx_ready,
  output logic [UART_DATA_BITS-1:0] rx_data,
  output logic                      rx_valid,
  input  logic                      rx_ready,
  output logic                      rx_overflow,
  output logic                      rx_frame_error
);

  localparam int unsigned     CPB      = calc_cpb(CLOCK_FREQUENCY, UART_BAUD_RATE);
  localparam int unsigned     CNT_W    = (CPB > 1) ? $clog2(CPB) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CPB - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CPB / 2);
  localparam logic [2:0]       IDX_LAST = 3'(UART_DATA_BITS - 1);

  // ---------------- transmitter ----------------
  tx_state_t                 tx_state, tx_state_n;
  logic [CNT_W-1:0]          tx_cnt, tx_cnt_n;
  logic [2:0]                tx_idx, tx_idx_n;
  logic [UART_DATA_BITS-1:0] tx_shift, tx_shift_n;
  logic                      tx_line, tx_line_n;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_shift <= '0;
      tx_line  <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_idx   <= tx_idx_n;
      tx_shift <= tx_shift_n;
      tx_line  <= tx_line_n;
    end
  end

  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt;
    tx_idx_n   = tx_idx;
    tx_shift_n = tx_shift;
    tx_line_n  = tx_line;
    case (tx_state)
      TX_IDLE: if (tx_valid) begin
        tx_state_n = TX_START;
        tx_shift_n = tx_data;
        tx_cnt_n   = '0;
        tx_line_n  = 1'b0;
      end
      TX_START: if (tx_cnt == CNT_LAST) begin
        tx_state_n = TX_DATA;
        tx_cnt_n   = '0;
        tx_idx_n   = '0;
        tx_line_n  = tx_shift[0];
      end else tx_cnt_n = tx_cnt + CNT_W'(1);
      TX_DATA: if (tx_cnt == CNT_LAST) begin
        tx_cnt_n = '0;
        if (tx_idx == IDX_LAST) begin
          tx_state_n = TX_STOP;
          tx_line_n  = 1'b1;
        end else begin
          tx_idx_n   = tx_idx + 3'd1;
          tx_shift_n = tx_shift >> 1;
          tx_line_n  = tx_shift[1];
        end
      end else tx_cnt_n = tx_cnt + CNT_W'(1);
      TX_STOP: if (tx_cnt == CNT_LAST) begin
        tx_state_n = TX_IDLE;
        tx_cnt_n   = '0;
      end else tx_cnt_n = tx_cnt + CNT_W'(1);
      default: tx_state_n = TX_IDLE;
    endcase
  end

  assign serial_tx = tx_line;
  assign tx_ready  = (tx_state == TX_IDLE);

  // ---------------- receiver ----------------
  logic rx_s1, rx_s2, rx_prev;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= serial_rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  rx_state_t                 rx_state, rx_state_n;
  logic [CNT_W-1:0]          rx_cnt, rx_cnt_n;
  logic [2:0]                rx_idx, rx_idx_n;
  logic [UART_DATA_BITS-1:0] rx_shift, rx_shift_n;
  logic                      rx_push, rx_ferr_d, rx_full;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_state       <= RX_IDLE;
      rx_cnt         <= '0;
      rx_idx         <= '0;
      rx_shift       <= '0;
      rx_frame_error <= 1'b0;
      rx_overflow    <= 1'b0;
    end else begin
      rx_state       <= rx_state_n;
      rx_cnt         <= rx_cnt_n;
      rx_idx         <= rx_idx_n;
      rx_shift       <= rx_shift_n;
      rx_frame_error <= rx_ferr_d;
      // Buffer state changes at this edge, so the drop is flagged with it.
      rx_overflow    <= rx_push && rx_full && !rx_ready;
    end
  end

  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt;
    rx_idx_n   = rx_idx;
    rx_shift_n = rx_shift;
    rx_push    = 1'b0;
    rx_ferr_d  = 1'b0;
    case (rx_state)
      RX_IDLE: if (rx_prev && !rx_s2) begin
        rx_state_n = RX_START;
        rx_cnt_n   = '0;
      end
      RX_START: if (rx_cnt == CNT_MID) begin
        rx_cnt_n   = '0;
        rx_idx_n   = '0;
        rx_state_n = rx_s2 ? RX_IDLE : RX_DATA;
      end else rx_cnt_n = rx_cnt + CNT_W'(1);
      RX_DATA: if (rx_cnt == CNT_LAST) begin
        rx_cnt_n   = '0;
        rx_shift_n = {rx_s2, rx_shift[UART_DATA_BITS-1:1]};
        if (rx_idx == IDX_LAST) rx_state_n = RX_STOP;
        else                    rx_idx_n   = rx_idx + 3'd1;
      end else rx_cnt_n = rx_cnt + CNT_W'(1);
      RX_STOP: if (rx_cnt == CNT_LAST) begin
        rx_cnt_n = '0;
        if (rx_s2) begin
          rx_push    = 1'b1;
          rx_state_n = RX_IDLE;
        end else begin
          rx_ferr_d  = 1'b1;
          rx_state_n = RX_BREAK;
        end
      end else rx_cnt_n = rx_cnt + CNT_W'(1);
      RX_BREAK: if (rx_s2) rx_state_n = RX_IDLE;
      default: rx_state_n = RX_IDLE;
    endcase
  end

  // ---------------- receive buffer ----------------
`ifdef UART_HOST_RX_FIFO_EN
  logic fifo_empty;

  uart_host_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (RX_FIFO_DEPTH)
  ) u_fifo (
    .clk       (clock),
    .rst_n     (reset),
    .push      (rx_push),
    .push_data (rx_shift),
    .pop       (rx_ready),
    .pop_data  (rx_data),
    .full      (rx_full),
    .empty     (fifo_empty)
  );

  assign rx_valid = !fifo_empty;
`else
  logic                      hold_valid;
  logic [UART_DATA_BITS-1:0] hold_data;
  logic                      unused_depth;

  // Depth only matters when the FIFO is built.
  assign unused_depth = (RX_FIFO_DEPTH == 0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hold_valid <= 1'b0;
      hold_data  <= '0;
    end else if (rx_push && (!hold_valid || rx_ready)) begin
      hold_valid <= 1'b1;
      hold_data  <= rx_shift;
    end else if (hold_valid && rx_ready) begin
      hold_valid <= 1'b0;
    end
  end

  assign rx_full  = hold_valid;
  assign rx_valid = hold_valid;
  assign rx_data  = hold_data;
`endif

endmodule

// File: tb/tb_uart_host_bridge.sv
module tb_uart_host_bridge;
  import uart_host_pkg::*;

`ifdef UART_HOST_RX_FIFO_EN
  localparam int DEPTH = 16;
`else
  localparam int DEPTH = 1;
`endif
  localparam int CPB = 10;

  logic       clock;
  logic       reset;
  logic       serial_rx;
  logic       serial_tx;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       rx_overflow;
  logic       rx_frame_error;

  int checks = 0;
  int passes = 0;
  int ferr_cnt = 0;
  int ovf_cnt = 0;
  logic [7:0] rx_q[$];

  uart_host_bridge #(
    .CLOCK_FREQUENCY (1000000),
    .UART_BAUD_RATE  (100000),
    .RX_FIFO_DEPTH   (16)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .serial_rx      (serial_rx),
    .serial_tx      (serial_tx),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .rx_ready       (rx_ready),
    .rx_overflow    (rx_overflow),
    .rx_frame_error (rx_frame_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (rx_frame_error === 1'b1) ferr_cnt++;
    if (rx_overflow === 1'b1) ovf_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    serial_rx = 1'b0;
    cyc(CPB);
    for (int i = 0; i < 8; i++) begin
      serial_rx = b[i];
      cyc(CPB);
    end
    serial_rx = stop;
    cyc(CPB);
  endtask

  // Waits (bounded) for rx_valid, then pops one byte and checks it against the queue.
  task automatic pop_check(input string tag);
    logic [7:0] exp;
    for (int i = 0; i < 300 && rx_valid !== 1'b1; i++) @(negedge clock);
    @(negedge clock);
    check({tag, "_valid"}, 32'(rx_valid), 32'd1);
    if (rx_q.size() == 0) begin
      check({tag, "_queue"}, 32'(rx_q.size()), 32'd1);
    end else begin
      exp = rx_q.pop_front();
      check({tag, "_data"}, 32'(rx_data), 32'(exp));
    end
    rx_ready = 1'b1;
    @(posedge clock);
    #1;
    rx_ready = 1'b0;
  endtask

  task automatic tx_frame(input logic [7:0] b);
    logic exp_bit;
    check("tx_ready_pre", 32'(tx_ready), 32'd1);
    tx_data  = b;
    tx_valid = 1'b1;
    @(posedge clock);
    #1;
    tx_valid = 1'b0;
    tx_data  = ~b;
    for (int k = 0; k < 10 * CPB; k++) begin
      @(negedge clock);
      if (k < CPB)           exp_bit = 1'b0;
      else if (k < 9 * CPB)  exp_bit = b[(k - CPB) / CPB];
      else                   exp_bit = 1'b1;
      check("tx_line", 32'(serial_tx), 32'(exp_bit));
      check("tx_busy", 32'(tx_ready), 32'd0);
    end
    @(negedge clock);
    check("tx_ready_post", 32'(tx_ready), 32'd1);
    check("tx_idle_line", 32'(serial_tx), 32'd1);
  endtask

  initial begin
    reset     = 1'b0;
    serial_rx = 1'b1;
    tx_data   = 8'h00;
    tx_valid  = 1'b0;
    rx_ready  = 1'b0;
    cyc(5);
    check("rst_serial_tx", 32'(serial_tx), 32'd1);
    check("rst_tx_ready", 32'(tx_ready), 32'd1);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    check("rst_overflow", 32'(rx_overflow), 32'd0);
    check("rst_frame_err", 32'(rx_frame_error), 32'd0);
    reset = 1'b1;
    cyc(3);

    // Transmit 0x55
    tx_frame(8'h55);
    cyc(2);

    // Receive 0xA3
    rx_q.push_back(8'hA3);
    send_frame(8'hA3, 1'b1);
    pop_check("rx_a3");
    check("rx_a3_ferr", 32'(ferr_cnt), 32'd0);
    check("rx_a3_ovf", 32'(ovf_cnt), 32'd0);
    cyc(2);
    check("rx_a3_empty", 32'(rx_valid), 32'd0);

    // 3-cycle glitch
    serial_rx = 1'b0;
    cyc(3);
    serial_rx = 1'b1;
    cyc(30);
    check("glitch_valid", 32'(rx_valid), 32'd0);
    check("glitch_ferr", 32'(ferr_cnt), 32'd0);
    check("glitch_idle", 32'(dut.rx_state), 32'(RX_IDLE));

    // Bad stop bit, then a good frame
    send_frame(8'h3C, 1'b0);
    cyc(20);
    serial_rx = 1'b1;
    cyc(20);
    check("ferr_count", 32'(ferr_cnt), 32'd1);
    check("ferr_empty", 32'(rx_valid), 32'd0);
    check("ferr_idle", 32'(dut.rx_state), 32'(RX_IDLE));
    rx_q.push_back(8'h7E);
    send_frame(8'h7E, 1'b1);
    pop_check("rx_7e");
    check("rx_7e_ferr", 32'(ferr_cnt), 32'd1);

    // Overflow: DEPTH+1 frames with no pops
    cyc(5);
    for (int n = 0; n <= DEPTH; n++) begin
      logic [7:0] b;
      b = 8'(8'h10 + n * 7);
      if (n < DEPTH) rx_q.push_back(b);
      send_frame(b, 1'b1);
    end
    cyc(5);
    check("ovf_count", 32'(ovf_cnt), 32'd1);
    check("ovf_valid", 32'(rx_valid), 32'd1);
    for (int n = 0; n < DEPTH; n++) pop_check("ovf_pop");
    cyc(2);
    check("ovf_drained", 32'(rx_valid), 32'd0);
    check("ovf_queue", 32'(rx_q.size()), 32'd0);
    check("ovf_count_final", 32'(ovf_cnt), 32'd1);

    // Reset in the middle of data bit 4 of a transmit frame
    tx_data  = 8'h81;
    tx_valid = 1'b1;
    @(posedge clock);
    #1;
    tx_valid = 1'b0;
    cyc(55);
    check("mid_tx_line", 32'(serial_tx), 32'd0);
    check("mid_tx_busy", 32'(tx_ready), 32'd0);
    reset = 1'b0;
    #2;
    check("abort_serial_tx", 32'(serial_tx), 32'd1);
    check("abort_tx_ready", 32'(tx_ready), 32'd1);
    cyc(3);
    reset = 1'b1;
    cyc(2);
    tx_frame(8'hC9);
    cyc(2);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
